// File: rtl/wholeass_sequencer.sv
// Bit-serial adder controller: one shared full-adder cell is stepped LSB-first
// across N bit positions. Operands and results move over valid/ready handshakes.

module wholeass (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    // Single-bit full adder
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

module wholeass_sequencer #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         busy
);

    localparam int unsigned CW = (N <= 1) ? 1 : $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_sum_sh;
    logic [N-1:0]  r_sum;
    logic          r_carry;
    logic          r_cout;
    logic [CW-1:0] r_bit_cnt;

    logic          w_cell_sum;
    logic          w_cell_cout;
    logic          w_accept;
    logic          w_last;
    logic [N-1:0]  w_sum_sh_nxt;

    // The one time-shared adder cell
    wholeass u_cell (
        .a         (r_a_sh[0]),
        .b         (r_b_sh[0]),
        .carry_in  (r_carry),
        .sum       (w_cell_sum),
        .carry_out (w_cell_cout)
    );

    // Handshake and status decode; start_ready is also gated by reset
    assign start_ready  = (r_state == S_IDLE) && !rst;
    assign result_valid = (r_state == S_DONE);
    assign busy         = (r_state == S_RUN) || (r_state == S_DONE);
    assign sum          = r_sum;
    assign carry_out    = r_cout;

    assign w_accept     = start_valid && start_ready;
    assign w_last       = (r_state == S_RUN) && (r_bit_cnt == CW'(N - 1));
    // Cell sum enters at the MSB while the accumulated bits move down
    assign w_sum_sh_nxt = N'({w_cell_sum, r_sum_sh} >> 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_state_nxt = S_RUN;
            S_RUN:   if (w_last)       w_state_nxt = S_DONE;
            S_DONE:  if (result_ready) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // Serial datapath: operand/sum shifters, carry, bit counter, result regs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_carry   <= 1'b0;
            r_bit_cnt <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_a_sh    <= a;
                    r_b_sh    <= b;
                    r_carry   <= carry_in;
                    r_bit_cnt <= '0;
                end
            end else if (r_state == S_RUN) begin
                r_sum_sh  <= w_sum_sh_nxt;
                r_a_sh    <= r_a_sh >> 1;
                r_b_sh    <= r_b_sh >> 1;
                r_carry   <= w_cell_cout;
                r_bit_cnt <= r_bit_cnt + CW'(1);
                if (w_last) begin
                    r_sum  <= w_sum_sh_nxt;
                    r_cout <= w_cell_cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_wholeass_sequencer.sv
// Directed bench for wholeass_sequencer at N=3 and N=1.

module tb_wholeass_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       sv3 = 1'b0, rr3 = 1'b0, ci3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       sr3, rv3, co3, bz3;
    logic [2:0] s3;

    logic       sv1 = 1'b0, rr1 = 1'b0, ci1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       sr1, rv1, co1, bz1;
    logic [0:0] s1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wholeass_sequencer #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .start_valid(sv3), .start_ready(sr3),
        .a(a3), .b(b3), .carry_in(ci3), .result_valid(rv3),
        .result_ready(rr3), .sum(s3), .carry_out(co3), .busy(bz3)
    );

    wholeass_sequencer #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1),
        .a(a1), .b(b1), .carry_in(ci1), .result_valid(rv1),
        .result_ready(rr1), .sum(s1), .carry_out(co1), .busy(bz1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full operation on the N=3 instance with fixed latency checks
    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic c);
        logic [3:0] e;
        e = 4'(a) + 4'(b) + 4'(c);
        a3 = a; b3 = b; ci3 = c; sv3 = 1'b1; rr3 = 1'b1;
        tick();
        sv3 = 1'b0;
        tick();
        tick();
        chk("sweep_rv_early", 32'(rv3), 32'd0);
        tick();
        chk("sweep_rv", 32'(rv3), 32'd1);
        chk("sweep_sum", 32'({co3, s3}), 32'(e));
        tick();
        chk("sweep_idle", 32'(sr3), 32'd1);
    endtask

    initial begin
        int last_acc;
        int nacc;
        int nres;
        logic [3:0] exp_q[$];
        logic [3:0] ex;

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        chk("rst_sum", 32'(s3), 32'd0);
        chk("rst_cout", 32'(co3), 32'd0);
        chk("rst_rv", 32'(rv3), 32'd0);
        chk("rst_busy", 32'(bz3), 32'd0);
        chk("rst_sr_held", 32'(sr3), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_sr_rel", 32'(sr3), 32'd1);

        // 5 + 6 + 0 with explicit edge timing
        a3 = 3'd5; b3 = 3'd6; ci3 = 1'b0; sv3 = 1'b1; rr3 = 1'b1;
        tick();
        sv3 = 1'b0;
        chk("basic_busy", 32'(bz3), 32'd1);
        chk("basic_sr_run", 32'(sr3), 32'd0);
        tick();
        chk("basic_rv_k1", 32'(rv3), 32'd0);
        tick();
        chk("basic_rv_k2", 32'(rv3), 32'd0);
        tick();
        chk("basic_rv_k3", 32'(rv3), 32'd1);
        chk("basic_sum", 32'(s3), 32'd3);
        chk("basic_cout", 32'(co3), 32'd1);
        tick();
        chk("basic_sr_k4", 32'(sr3), 32'd1);
        chk("basic_rv_k4", 32'(rv3), 32'd0);
        chk("basic_hold_sum", 32'(s3), 32'd3);

        // Exhaustive N=3 sweep
        for (int i = 0; i < 128; i++) begin
            op3(3'(i >> 4), 3'(i >> 1), 1'(i));
        end

        // Backpressure with new operands offered during RUN/DONE
        a3 = 3'd7; b3 = 3'd0; ci3 = 1'b1; sv3 = 1'b1; rr3 = 1'b0;
        tick();
        a3 = 3'd3; b3 = 3'd3; ci3 = 1'b0;
        tick();
        tick();
        tick();
        chk("bp_rv_rise", 32'(rv3), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_sum", 32'(s3), 32'd0);
            chk("bp_cout", 32'(co3), 32'd1);
            chk("bp_rv", 32'(rv3), 32'd1);
            chk("bp_sr", 32'(sr3), 32'd0);
            chk("bp_busy", 32'(bz3), 32'd1);
        end
        sv3 = 1'b0; rr3 = 1'b1;
        tick();
        chk("bp_release_sr", 32'(sr3), 32'd1);
        chk("bp_release_busy", 32'(bz3), 32'd0);
        chk("bp_release_hold", 32'({co3, s3}), 32'h8);

        // Reset at the second RUN edge aborts the operation
        a3 = 3'd3; b3 = 3'd4; ci3 = 1'b1; sv3 = 1'b1; rr3 = 1'b1;
        tick();
        sv3 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_sum", 32'(s3), 32'd0);
        chk("abort_cout", 32'(co3), 32'd0);
        chk("abort_rv", 32'(rv3), 32'd0);
        chk("abort_busy", 32'(bz3), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_rv", 32'(rv3), 32'd0);
        end

        // Streaming: start_valid and result_ready held high for 10 operations
        last_acc = -1; nacc = 0; nres = 0;
        sv3 = 1'b1; rr3 = 1'b1;
        for (int cyc = 0; cyc < 80 && nres < 10; cyc++) begin
            if (sr3) begin
                if (nacc < 10) begin
                    a3 = 3'(nacc * 3 + 1); b3 = 3'(7 - nacc); ci3 = 1'(nacc);
                    exp_q.push_back(4'(a3) + 4'(b3) + 4'(ci3));
                    if (last_acc >= 0) chk("tput_gap", 32'(cyc - last_acc), 32'd5);
                    last_acc = cyc;
                    nacc++;
                end else begin
                    sv3 = 1'b0;
                end
            end
            tick();
            if (rv3) begin
                ex = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
                chk("tput_sum", 32'({co3, s3}), 32'(ex));
                nres++;
            end
        end
        sv3 = 1'b0;
        chk("tput_count", 32'(nres), 32'd10);

        // Exhaustive N=1 sweep
        rr1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic ea, eb, ec;
            ea = 1'(i >> 2); eb = 1'(i >> 1); ec = 1'(i);
            a1 = ea; b1 = eb; ci1 = ec; sv1 = 1'b1;
            tick();
            sv1 = 1'b0;
            chk("n1_run_rv", 32'(rv1), 32'd0);
            tick();
            chk("n1_rv", 32'(rv1), 32'd1);
            chk("n1_sum", 32'(s1), 32'(ea ^ eb ^ ec));
            chk("n1_cout", 32'(co1), 32'((ea & eb) | (ea & ec) | (eb & ec)));
            tick();
            chk("n1_idle", 32'(sr1), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
